// File: rtl/force_wb_arbiter.sv
// Buffers per-accumulator force results in small FIFOs and drains them through
// one round-robin arbitrated valid/ready writeback port, with round tracking.
module force_wb_arbiter #(
    parameter int NUM_ACC           = 7,
    parameter int DATA_WIDTH        = 32,
    parameter int PARTICLE_ID_WIDTH = 20,
    parameter int CELL_ID_WIDTH     = 3,
    parameter int ID_WIDTH          = 3*CELL_ID_WIDTH+PARTICLE_ID_WIDTH,
    parameter int FIFO_DEPTH        = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_ACC-1:0]              in_valid,
    input  logic [NUM_ACC*ID_WIDTH-1:0]     in_particle_id,
    input  logic [NUM_ACC*DATA_WIDTH-1:0]   in_force_x,
    input  logic [NUM_ACC*DATA_WIDTH-1:0]   in_force_y,
    input  logic [NUM_ACC*DATA_WIDTH-1:0]   in_force_z,
    input  logic [NUM_ACC-1:0]              in_start_wb,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [ID_WIDTH-1:0]             out_particle_id,
    output logic [DATA_WIDTH-1:0]           out_force_x,
    output logic [DATA_WIDTH-1:0]           out_force_y,
    output logic [DATA_WIDTH-1:0]           out_force_z,
    output logic [2:0]                      out_src,
    output logic                            busy,
    output logic                            round_done,
    output logic [NUM_ACC-1:0]              overflow_err
);
    localparam int ENTRY_W = ID_WIDTH + 3*DATA_WIDTH;
    localparam int AW      = $clog2(FIFO_DEPTH);

    logic [ENTRY_W-1:0]                 mem_q [NUM_ACC][FIFO_DEPTH];
    logic [NUM_ACC-1:0][AW:0]           wr_ptr_q, rd_ptr_q;
    logic [NUM_ACC-1:0][ENTRY_W-1:0]    in_entry;
    logic [NUM_ACC-1:0]                 empty, full, push, pop, drop;
    logic [NUM_ACC-1:0]                 overflow_q;

    logic                               load, grant_vld;
    logic [2:0]                         grant_idx;
    logic [ENTRY_W-1:0]                 head;

    logic                               out_valid_q, out_valid_d;
    logic [2:0]                         out_src_q, out_src_d;
    logic [ENTRY_W-1:0]                 out_data_q, out_data_d;
    logic [2:0]                         ptr_q, ptr_d;
    logic                               round_active_q, round_active_d;
    logic                               round_done_q, round_done_d;

    // FIFO status; the extra pointer bit distinguishes full from empty
    always_comb begin
        for (int i = 0; i < NUM_ACC; i++) begin
            empty[i]    = (wr_ptr_q[i] == rd_ptr_q[i]);
            full[i]     = (wr_ptr_q[i][AW] != rd_ptr_q[i][AW]) &&
                          (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]);
            in_entry[i] = {in_particle_id[i*ID_WIDTH +: ID_WIDTH],
                           in_force_x[i*DATA_WIDTH +: DATA_WIDTH],
                           in_force_y[i*DATA_WIDTH +: DATA_WIDTH],
                           in_force_z[i*DATA_WIDTH +: DATA_WIDTH]};
        end
    end

    assign load = !out_valid_q || out_ready;

    // Descending scan so the closest non-empty FIFO above the pointer wins last
    always_comb begin
        logic [3:0] sum;
        grant_vld = 1'b0;
        grant_idx = '0;
        sum       = '0;
        for (int k = NUM_ACC-1; k >= 0; k--) begin
            sum = {1'b0, ptr_q} + 4'(k);
            if (sum >= 4'(NUM_ACC))
                sum = sum - 4'(NUM_ACC);
            if (!empty[sum[2:0]]) begin
                grant_vld = 1'b1;
                grant_idx = sum[2:0];
            end
        end
    end

    assign head = mem_q[grant_idx][rd_ptr_q[grant_idx][AW-1:0]];

    // A full FIFO still accepts a write when it is popped in the same cycle
    always_comb begin
        for (int i = 0; i < NUM_ACC; i++) begin
            pop[i]  = load && grant_vld && (grant_idx == 3'(i));
            push[i] = in_valid[i] && (!full[i] || pop[i]);
            drop[i] = in_valid[i] && full[i] && !pop[i];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_ACC; i++)
            if (push[i])
                mem_q[i][wr_ptr_q[i][AW-1:0]] <= in_entry[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= '0;
        end else begin
            for (int i = 0; i < NUM_ACC; i++) begin
                if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + (AW+1)'(1);
                if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + (AW+1)'(1);
                if (drop[i]) overflow_q[i] <= 1'b1;
            end
        end
    end

    always_comb begin
        out_valid_d    = out_valid_q;
        out_src_d      = out_src_q;
        out_data_d     = out_data_q;
        ptr_d          = ptr_q;
        if (load) begin
            out_valid_d = grant_vld;
            if (grant_vld) begin
                out_src_d  = grant_idx;
                out_data_d = head;
                ptr_d      = (grant_idx == 3'(NUM_ACC-1)) ? 3'd0 : grant_idx + 3'd1;
            end
        end
        // Round closes only when nothing is buffered, presented or arriving
        round_done_d   = round_active_q && (&empty) && !out_valid_q &&
                         !(|in_valid) && !(|in_start_wb);
        round_active_d = round_active_q;
        if (|in_start_wb)
            round_active_d = 1'b1;
        else if (round_done_d)
            round_active_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q    <= 1'b0;
            out_src_q      <= '0;
            out_data_q     <= '0;
            ptr_q          <= '0;
            round_active_q <= 1'b0;
            round_done_q   <= 1'b0;
        end else begin
            out_valid_q    <= out_valid_d;
            out_src_q      <= out_src_d;
            out_data_q     <= out_data_d;
            ptr_q          <= ptr_d;
            round_active_q <= round_active_d;
            round_done_q   <= round_done_d;
        end
    end

    assign out_valid       = out_valid_q;
    assign out_src         = out_src_q;
    assign out_particle_id = out_data_q[ENTRY_W-1 -: ID_WIDTH];
    assign out_force_x     = out_data_q[3*DATA_WIDTH-1 -: DATA_WIDTH];
    assign out_force_y     = out_data_q[2*DATA_WIDTH-1 -: DATA_WIDTH];
    assign out_force_z     = out_data_q[DATA_WIDTH-1:0];
    assign busy            = !(&empty) || out_valid_q;
    assign round_done      = round_done_q;
    assign overflow_err    = overflow_q;

endmodule

// File: tb/tb_force_wb_arbiter.sv
// Randomized and directed bench for force_wb_arbiter against a queue-based reference model.
module tb_force_wb_arbiter;
    localparam int N   = 7;
    localparam int DW  = 32;
    localparam int IW  = 29;
    localparam int EW  = IW + 3*DW;
    localparam int DEP = 4;

    logic             clk, rst_n;
    logic [N-1:0]     in_valid, in_start_wb;
    logic [N*IW-1:0]  in_particle_id;
    logic [N*DW-1:0]  in_force_x, in_force_y, in_force_z;
    logic             out_valid, out_ready;
    logic [IW-1:0]    out_particle_id;
    logic [DW-1:0]    out_force_x, out_force_y, out_force_z;
    logic [2:0]       out_src;
    logic             busy, round_done;
    logic [N-1:0]     overflow_err;

    int checks = 0;
    int passed = 0;

    force_wb_arbiter dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_particle_id(in_particle_id),
        .in_force_x(in_force_x), .in_force_y(in_force_y), .in_force_z(in_force_z),
        .in_start_wb(in_start_wb), .out_valid(out_valid), .out_ready(out_ready),
        .out_particle_id(out_particle_id), .out_force_x(out_force_x),
        .out_force_y(out_force_y), .out_force_z(out_force_z), .out_src(out_src),
        .busy(busy), .round_done(round_done), .overflow_err(overflow_err)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1);
    end

    // Reference model: per-requester lists, one presented beat, rotating priority
    logic [EW-1:0] mfifo [N][DEP];
    int            mcnt [N];
    logic          m_ov, m_rdone, m_ract;
    logic [2:0]    m_src;
    logic [EW-1:0] m_data;
    logic [N-1:0]  m_ovf;
    int            m_ptr;

    task automatic model_reset();
        for (int i = 0; i < N; i++) mcnt[i] = 0;
        m_ov = 0; m_src = 0; m_data = '0; m_ptr = 0;
        m_ovf = '0; m_ract = 0; m_rdone = 0;
    endtask

    function automatic logic m_busy();
        logic b;
        b = m_ov;
        for (int i = 0; i < N; i++) if (mcnt[i] > 0) b = 1;
        return b;
    endfunction

    task automatic model_edge();
        logic load, done;
        int g, j;
        load = !m_ov || out_ready;
        done = m_ract && !m_busy() && (in_valid == 0) && (in_start_wb == 0);
        g = -1;
        if (load)
            for (int k = 0; k < N; k++) begin
                j = (m_ptr + k) % N;
                if (g < 0 && mcnt[j] > 0) g = j;
            end
        if (load) begin
            if (g >= 0) begin
                m_ov = 1; m_src = 3'(g); m_data = mfifo[g][0];
                for (int s = 0; s < DEP-1; s++) mfifo[g][s] = mfifo[g][s+1];
                mcnt[g] = mcnt[g] - 1;
                m_ptr = (g + 1) % N;
            end else m_ov = 0;
        end
        for (int i = 0; i < N; i++)
            if (in_valid[i]) begin
                if (mcnt[i] < DEP) begin
                    mfifo[i][mcnt[i]] = {in_particle_id[i*IW +: IW], in_force_x[i*DW +: DW],
                                         in_force_y[i*DW +: DW], in_force_z[i*DW +: DW]};
                    mcnt[i] = mcnt[i] + 1;
                end else m_ovf[i] = 1;
            end
        m_rdone = done;
        if (in_start_wb != 0) m_ract = 1;
        else if (done) m_ract = 0;
    endtask

    function automatic logic [137:0] exp_vec();
        return {m_busy(), m_rdone, m_ovf, m_ov, m_ov ? {m_src, m_data} : 128'b0};
    endfunction

    function automatic logic [137:0] dut_vec();
        return {busy, round_done, overflow_err, out_valid,
                out_valid ? {out_src, out_particle_id, out_force_x, out_force_y, out_force_z} : 128'b0};
    endfunction

    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge();
        #1;
    endtask

    task automatic clear_inputs();
        in_valid = '0; in_start_wb = '0;
        in_particle_id = '0; in_force_x = '0; in_force_y = '0; in_force_z = '0;
    endtask

    task automatic set_beat(input int i, input logic [IW-1:0] id,
                            input logic [DW-1:0] fx, input logic [DW-1:0] fy, input logic [DW-1:0] fz);
        in_particle_id[i*IW +: IW] = id;
        in_force_x[i*DW +: DW] = fx;
        in_force_y[i*DW +: DW] = fy;
        in_force_z[i*DW +: DW] = fz;
        in_valid[i] = 1'b1;
    endtask

    task automatic do_reset();
        clear_inputs();
        out_ready = 0;
        rst_n = 0;
        step();
        step();
        rst_n = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        out_ready = 0;
        rst_n = 0;
        step();
        step();
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        checks++; if (round_done !== 1'b0) $display("FAIL reset_round_done: got %b want 0", round_done); else passed++;
        checks++; if (overflow_err !== 7'b0) $display("FAIL reset_overflow: got %b want 0", overflow_err); else passed++;
        checks++;
        if ({out_src, out_particle_id, out_force_x, out_force_y, out_force_z} !== 128'b0)
            $display("FAIL reset_data: got %h want 0", {out_src, out_particle_id, out_force_x, out_force_y, out_force_z});
        else passed++;
        rst_n = 1;
    endtask

    task automatic test_single_beat();
        do_reset();
        out_ready = 1;
        set_beat(2, 29'h0A5, 32'h3F800000, 32'h40000000, 32'hBF800000);
        step();
        clear_inputs();
        checks++; if (out_valid !== 1'b0) $display("FAIL single_early: got out_valid %b want 0", out_valid); else passed++;
        step();
        checks++;
        if ({out_valid, out_src, out_particle_id, out_force_x, out_force_y, out_force_z} !==
            {1'b1, 3'd2, 29'h0A5, 32'h3F800000, 32'h40000000, 32'hBF800000})
            $display("FAIL single_beat: got %b/%0d/%h/%h/%h/%h want 1/2/0a5/3f800000/40000000/bf800000",
                     out_valid, out_src, out_particle_id, out_force_x, out_force_y, out_force_z);
        else passed++;
        step();
        checks++;
        if ({out_valid, busy} !== 2'b00) $display("FAIL single_after: got valid,busy %b want 00", {out_valid, busy});
        else passed++;
        checks++;
        if (dut_vec() !== exp_vec()) $display("FAIL single_model: got %h want %h", dut_vec(), exp_vec());
        else passed++;
    endtask

    task automatic test_fairness();
        logic [20:0] ord, want;
        int nb;
        do_reset();
        out_ready = 1;
        for (int i = 0; i < N; i++) set_beat(i, 29'(i), $urandom, $urandom, $urandom);
        step();
        clear_inputs();
        ord = '0; nb = 0;
        for (int c = 0; c < 9; c++) begin
            checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL fair_cyc%0d: got %h want %h", c, dut_vec(), exp_vec());
            else passed++;
            if (out_valid) begin
                ord = {ord[17:0], out_src};
                nb++;
            end
            step();
        end
        want = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
        checks++;
        if (ord !== want || nb != 7) $display("FAIL fair_order: got %h (%0d beats) want %h (7 beats)", ord, nb, want);
        else passed++;
        set_beat(6, 29'h66, $urandom, $urandom, $urandom);
        set_beat(0, 29'h11, $urandom, $urandom, $urandom);
        step();
        clear_inputs();
        step();
        checks++;
        if ({out_valid, out_src} !== {1'b1, 3'd0}) $display("FAIL fair_ptr_wrap: got %b/%0d want 1/0", out_valid, out_src);
        else passed++;
        for (int c = 0; c < 3; c++) step();
    endtask

    task automatic test_backpressure();
        logic [127:0] snap;
        int total, acc, guard;
        logic [N-1:0] m;
        out_ready = 0;
        total = 0;
        for (int p = 0; p < 2; p++) begin
            m = 7'($urandom) | 7'(1 << $urandom_range(0, N-1));
            for (int i = 0; i < N; i++) if (m[i]) set_beat(i, 29'($urandom), $urandom, $urandom, $urandom);
            total += $countones(m);
            step();
            clear_inputs();
        end
        snap = {out_src, out_particle_id, out_force_x, out_force_y, out_force_z};
        checks++; if (out_valid !== 1'b1) $display("FAIL bp_presented: got %b want 1", out_valid); else passed++;
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if ({out_valid, out_src, out_particle_id, out_force_x, out_force_y, out_force_z} !== {1'b1, snap})
                $display("FAIL bp_stable%0d: got %h want %h", c,
                         {out_valid, out_src, out_particle_id, out_force_x, out_force_y, out_force_z}, {1'b1, snap});
            else passed++;
        end
        out_ready = 1;
        acc = 0; guard = 0;
        while (busy && guard < 40) begin
            if (out_valid && out_ready) acc++;
            step();
            guard++;
            checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL bp_drain%0d: got %h want %h", guard, dut_vec(), exp_vec());
            else passed++;
        end
        checks++;
        if (acc != total || guard >= 40) $display("FAIL bp_count: got %0d beats (guard %0d) want %0d", acc, guard, total);
        else passed++;
    endtask

    task automatic test_overflow();
        int ids [8];
        int cnt, guard;
        do_reset();
        out_ready = 0;
        set_beat(0, 29'h100, $urandom, $urandom, $urandom);
        step();
        clear_inputs();
        step();
        for (int n = 1; n <= 5; n++) begin
            set_beat(3, 29'(n), $urandom, $urandom, $urandom);
            step();
            clear_inputs();
        end
        checks++;
        if (overflow_err !== 7'b0001000) $display("FAIL ovf_flag: got %b want 0001000", overflow_err);
        else passed++;
        out_ready = 1;
        cnt = 0; guard = 0;
        while (busy && guard < 30) begin
            if (out_valid && out_src == 3'd3 && cnt < 8) begin
                ids[cnt] = int'(out_particle_id);
                cnt++;
            end
            step();
            guard++;
            checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL ovf_drain%0d: got %h want %h", guard, dut_vec(), exp_vec());
            else passed++;
        end
        checks++;
        if (cnt != 4 || ids[0] != 1 || ids[1] != 2 || ids[2] != 3 || ids[3] != 4)
            $display("FAIL ovf_ids: got %0d ids first %0d,%0d,%0d,%0d want 4 ids 1,2,3,4",
                     cnt, ids[0], ids[1], ids[2], ids[3]);
        else passed++;
    endtask

    task automatic test_round();
        int n, last_ov, rd_at, pulses;
        do_reset();
        out_ready = 1;
        n = 0; last_ov = -100; rd_at = -1; pulses = 0;
        in_start_wb = 7'b0000001;
        step(); n++;
        in_start_wb = '0;
        for (int p = 0; p < 3; p++) begin
            set_beat(5, 29'(p + 10), $urandom, 32'h0, $urandom);
            step(); n++;
            clear_inputs();
            if (out_valid) last_ov = n;
        end
        for (int c = 0; c < 15; c++) begin
            step(); n++;
            if (out_valid) last_ov = n;
            if (round_done) begin
                pulses++;
                if (rd_at < 0) rd_at = n;
            end
            checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL round_cyc%0d: got %h want %h", c, dut_vec(), exp_vec());
            else passed++;
        end
        checks++;
        if (pulses != 1 || rd_at != last_ov + 2)
            $display("FAIL round_pulse: got %0d pulses at %0d want 1 at %0d", pulses, rd_at, last_ov + 2);
        else passed++;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            clear_inputs();
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 3) == 0)
                    set_beat(i, 29'($urandom), ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom, $urandom, $urandom);
            if ($urandom_range(0, 19) == 0) in_start_wb = 7'(1 << $urandom_range(0, N-1));
            out_ready = ($urandom_range(0, 3) != 0);
            step();
            checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL rand_cyc%0d: got %h want %h", c, dut_vec(), exp_vec());
            else passed++;
        end
        clear_inputs();
        out_ready = 1;
        for (int c = 0; c < 30; c++) begin
            step();
            checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL rand_drain%0d: got %h want %h", c, dut_vec(), exp_vec());
            else passed++;
        end
    endtask

    task automatic test_async_reset();
        int stale;
        out_ready = 1;
        for (int i = 0; i < N; i++) set_beat(i, 29'(i + 40), $urandom, $urandom, $urandom);
        step();
        clear_inputs();
        step();
        step();
        #2;
        rst_n = 0;
        #1;
        checks++;
        if ({out_valid, busy, overflow_err} !== 9'b0)
            $display("FAIL async_reset: got valid %b busy %b ovf %b want all 0", out_valid, busy, overflow_err);
        else passed++;
        model_reset();
        #2;
        rst_n = 1;
        stale = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (out_valid) stale++;
            checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL async_post%0d: got %h want %h", c, dut_vec(), exp_vec());
            else passed++;
        end
        checks++;
        if (stale != 0) $display("FAIL async_stale: got %0d beats want 0", stale);
        else passed++;
    endtask

    initial begin
        rst_n = 0;
        out_ready = 0;
        clear_inputs();
        model_reset();
        test_reset();
        test_single_beat();
        test_fairness();
        test_backpressure();
        test_overflow();
        test_round();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/force_wb_arbiter.md
Name: force_wb_arbiter

Overview:
- Collects accumulated per-reference-particle forces from the NUM_ACC parallel partial-force accumulators of one evaluation unit.
- Accumulators emit single-cycle, non-stallable valid pulses, so each input is buffered in a per-requester FIFO.
- FIFOs are drained through one round-robin-arbitrated valid/ready writeback port into the force cache.
- Also tracks writeback rounds and flags buffer overflow.

Parameters:
- NUM_ACC, 7, number of accumulator requesters.
- DATA_WIDTH, 32, IEEE-754 single-precision force component width.
- PARTICLE_ID_WIDTH, 20, particle index bits.
- CELL_ID_WIDTH, 3, per-axis cell ID bits.
- ID_WIDTH, 3*CELL_ID_WIDTH+PARTICLE_ID_WIDTH, full reference ID width.
- FIFO_DEPTH, 4, entries per requester FIFO; power of two, at least 2.

Ports:
- clk, in, 1, single clock.
- rst_n, in, 1, asynchronous active-low reset.
- in_valid, in, NUM_ACC, per-requester accumulated-force valid pulse.
- in_particle_id, in, NUM_ACC*ID_WIDTH, packed IDs; requester i occupies bits [i*ID_WIDTH +: ID_WIDTH].
- in_force_x / in_force_y / in_force_z, in, NUM_ACC*DATA_WIDTH each, packed the same way.
- in_start_wb, in, NUM_ACC, per-requester start-of-writeback pulse.
- out_valid, out, 1, writeback beat valid.
- out_ready, in, 1, force cache accepts the beat.
- out_particle_id, out, ID_WIDTH, ID of the beat.
- out_force_x / out_force_y / out_force_z, out, DATA_WIDTH each, force of the beat.
- out_src, out, 3, index of the requester that sourced the beat.
- busy, out, 1, any FIFO non-empty or out_valid high.
- round_done, out, 1, one-cycle pulse when a writeback round fully drains.
- overflow_err, out, NUM_ACC, sticky per-requester drop flag.

Behaviour:
- Reset: asynchronous on rst_n low.
  - All FIFOs are emptied.
  - Round-robin pointer returns to 0.
  - All outputs go to 0; out_valid=0, busy=0, round_done=0, overflow_err=0.
  - Reset mid-transfer discards all buffered and presented data; no handshake is completed.
- Capture: when in_valid[i]=1 at a rising edge, {id, fx, fy, fz} of slice i is written into FIFO i. All NUM_ACC requesters may write in the same cycle.
- Overflow: a write to a full FIFO with no same-cycle pop is dropped, and overflow_err[i] is set and held until reset. If the FIFO is full but popped in the same cycle, the write is accepted.
- Output register: "load" is true when out_valid=0, or out_valid=1 and out_ready=1.
  - On load, if any FIFO is non-empty, the winner is popped into the output registers, out_valid=1, and out_src is set to the winner index. Otherwise out_valid=0.
  - While out_valid=1 and out_ready=0, all out_* signals hold stable.
- Arbitration: round-robin over non-empty FIFOs, searching upward from the pointer with wrap-around. After a grant, the pointer becomes (winner+1) mod NUM_ACC. The pointer is unchanged when there is no grant.
- Latency and throughput:
  - Data sampled at edge k is eligible for arbitration after edge k and can appear on out_valid after edge k+1 (2 cycles in-to-out, minimum).
  - Sustained throughput is 1 beat per cycle while out_ready=1.
- Data is never modified. Zero-valued forces pass through like any other value.
- Round tracking: a round_active flag is set by any in_start_wb bit at an edge.
  - round_done pulses for exactly one cycle on the first edge where all of these hold: round_active=1, all FIFOs empty, out_valid=0, no in_valid bit set, no in_start_wb bit set.
  - round_active is cleared on that same edge.
  - A start pulse arriving while round_active=1 is absorbed into the current round.
- busy is computed combinationally from FIFO occupancy and out_valid.

Test Plan:
- Single beat: reset, out_ready=1, in_valid=7'b0000100 with id=0x0A5, fx=0x3F800000 (1.0), fy=0x40000000 (2.0), fz=0xBF800000 (-1.0). Required: out_valid=1 exactly 2 cycles later for one cycle, with out_src=2 and identical data. busy then drops.
- Fairness: all 7 requesters pulse once in the same cycle with id=i, out_ready=1. Required: beats come out on consecutive cycles in order 0,1,2,3,4,5,6, and the pointer ends at 0.
- Backpressure: hold out_ready=0 for 5 cycles with beats pending. Required: out_* remain stable. On out_ready=1, the remaining beats drain one per cycle with no loss or duplication.
- Overflow: out_ready=0, pulse requester 3 five times with ids 1..5 (FIFO_DEPTH=4). Required: overflow_err=7'b0001000. After release, the ids delivered are 1,2,3,4 only.
- Round: pulse in_start_wb[0], then 3 force pulses on requester 5, out_ready=1. Required: exactly one round_done pulse, on the cycle after the last beat is accepted. No further pulses while idle.
- Async reset: assert rst_n=0 mid-drain, between clock edges. Required: out_valid, busy and overflow_err are 0 immediately. After release, no stale beats are emitted.
